// File: rtl/sbus_pkg.sv
// Shared types and constants for the GPIO emulator slave-bus initiator.
package sbus_pkg;

  localparam int SBUS_ADDR_W = 16;
  localparam int SBUS_DATA_W = 32;
  localparam int SBUS_CNT_W  = 4;

  localparam logic [15:0] GPIO_ADDR_AXIS1 = 16'h6ba0;
  localparam logic [15:0] GPIO_ADDR_AXIS2 = 16'hdb10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } sbus_state_t;

endpackage

// File: rtl/sbus_phase_cnt.sv
// Loadable down-counter with zero flag; times the setup, strobe and hold phases.
module sbus_phase_cnt
  import sbus_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  load,
  input  logic [SBUS_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [SBUS_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sbus_master.sv
// Slave-bus initiator: one command at a time, sequenced through setup, strobe
// and hold phases, answered over a response handshake. All outputs registered.
module sbus_master
  import sbus_pkg::*;
#(
  parameter int ADDR_W     = SBUS_ADDR_W,
  parameter int DATA_W     = SBUS_DATA_W,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] saddress,
  output logic [DATA_W-1:0] sdata_in,
  output logic              srd,
  output logic              swr,
  input  logic [DATA_W-1:0] sdata_out,
  output logic              busy
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 0 || HOLD_CYC > 15) begin : g_bad_params
    $error("sbus_master: phase cycle parameter out of range");
  end

  localparam logic [SBUS_CNT_W-1:0] SETUP_LD  = SBUS_CNT_W'(SETUP_CYC - 1);
  localparam logic [SBUS_CNT_W-1:0] STROBE_LD = SBUS_CNT_W'(STROBE_CYC - 1);
  localparam logic [SBUS_CNT_W-1:0] HOLD_LD   =
    (HOLD_CYC > 0) ? SBUS_CNT_W'(HOLD_CYC - 1) : '0;

  sbus_state_t           state;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [SBUS_CNT_W-1:0] cnt_val;
  logic                  cnt_zero;

  sbus_phase_cnt u_cnt (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter is loaded on the same edge the FSM enters the phase it times.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = STROBE_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          cnt_load = (HOLD_CYC > 0);
          cnt_val  = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  // rsp_we doubles as the latched command direction for the whole transaction.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      saddress  <= '0;
      sdata_in  <= '0;
      srd       <= 1'b0;
      swr       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_we    <= cmd_we;
            rsp_rdata <= '0;
            saddress  <= cmd_addr;
            sdata_in  <= cmd_we ? cmd_wdata : '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            swr   <= rsp_we;
            srd   <= !rsp_we;
            state <= STROBE;
          end
        end
        STROBE: begin
          if (cnt_zero) begin
            swr <= 1'b0;
            srd <= 1'b0;
            if (!rsp_we) begin
              rsp_rdata <= sdata_out;
            end
            if (HOLD_CYC == 0) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
